fm_sweep_wb_master: RTL and testbench

Wishbone pipelined bus master that drives the FM generator's carrier-center-frequency register (address 0) through a linear frequency sweep. On a start pulse it writes `count` successive increments (start, start+step, …), holding each for a programmable dwell, then reports done. It sits between control logic (or a CPU-less test harness) and the generator's Wishbone slave port, and is the initiator for that register interface.

---
 rtl/fm_sweep_wb_master.sv | 222 ++++++++++++++++++++++
 tb/tb_fm_sweep_wb_master.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fm_sweep_wb_master.sv
// Wishbone pipelined master that sweeps the FM carrier-center-frequency register (address 0).
// Optional FM_SWEEP_READBACK_EN: read back and verify every written point.
module fm_sweep_wb_master #(
   parameter int unsigned ADDR_W  = 2,
   parameter int unsigned DWELL_W = 24,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_start,
   input  logic               i_abort,
   input  logic [31:0]        i_start_freq,
   input  logic [31:0]        i_step,
   input  logic [15:0]        i_count,
   input  logic [DWELL_W-1:0] i_dwell,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_err,
   output logic               o_wb_cyc,
   output logic               o_wb_stb,
   output logic               o_wb_we,
   output logic [ADDR_W-1:0]  o_wb_addr,
   output logic [31:0]        o_wb_data,
   input  logic               i_wb_ack,
   input  logic               i_wb_stall,
   input  logic [31:0]        i_wb_data
);
   localparam int unsigned     TO_W    = $clog2(TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_ACK, S_DWELL,
`ifdef FM_SWEEP_READBACK_EN
      S_RREQ, S_RACK,
`endif
      S_DONE
   } state_t;

   state_t             state;
   logic [31:0]        freq;
   logic [31:0]        step;
   logic [15:0]        remaining;
   logic [DWELL_W-1:0] dwell;
   logic [DWELL_W-1:0] dcnt;
   logic [TO_W-1:0]    tcnt;
   logic               abort_pend;
   logic               abort_any;

   assign abort_any = abort_pend | i_abort;
   assign o_wb_addr = '0;

`ifndef FM_SWEEP_READBACK_EN
   logic unused_rdata;
   assign unused_rdata = ^i_wb_data;
`endif

   // Sweep sequencer: one outstanding transaction, every output registered.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state      <= S_IDLE;
         freq       <= '0;
         step       <= '0;
         remaining  <= '0;
         dwell      <= '0;
         dcnt       <= '0;
         tcnt       <= '0;
         abort_pend <= 1'b0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
         o_err      <= 1'b0;
         o_wb_cyc   <= 1'b0;
         o_wb_stb   <= 1'b0;
         o_wb_we    <= 1'b0;
         o_wb_data  <= '0;
      end else begin
         o_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (i_start && !i_abort) begin
                  freq       <= i_start_freq;
                  step       <= i_step;
                  remaining  <= i_count;
                  dwell      <= i_dwell;
                  o_err      <= 1'b0;
                  o_busy     <= 1'b1;
                  abort_pend <= 1'b0;
                  if (i_count == 16'd0) begin
                     state  <= S_DONE;
                     o_done <= 1'b1;
                  end else begin
                     state     <= S_REQ;
                     o_wb_cyc  <= 1'b1;
                     o_wb_stb  <= 1'b1;
                     o_wb_we   <= 1'b1;
                     o_wb_data <= i_start_freq;
                  end
               end
            end
            S_REQ: begin
               if (!i_wb_stall) begin
                  state    <= S_ACK;
                  o_wb_stb <= 1'b0;
                  tcnt     <= TO_W'(1);
                  if (i_abort) abort_pend <= 1'b1;
               end else if (abort_any) begin
                  state    <= S_DONE;
                  o_wb_cyc <= 1'b0;
                  o_wb_stb <= 1'b0;
                  o_wb_we  <= 1'b0;
                  o_done   <= 1'b1;
               end
            end
            S_ACK: begin
               if (i_wb_ack) begin
                  freq      <= freq + step;
                  remaining <= remaining - 16'd1;
`ifdef FM_SWEEP_READBACK_EN
                  if (abort_any) begin
                     state    <= S_DONE;
                     o_wb_cyc <= 1'b0;
                     o_wb_we  <= 1'b0;
                     o_done   <= 1'b1;
                  end else begin
                     state    <= S_RREQ;
                     o_wb_stb <= 1'b1;
                     o_wb_we  <= 1'b0;
                  end
`else
                  if (abort_any || remaining == 16'd1) begin
                     state    <= S_DONE;
                     o_wb_cyc <= 1'b0;
                     o_wb_we  <= 1'b0;
                     o_done   <= 1'b1;
                  end else if (dwell == '0) begin
                     state     <= S_REQ;
                     o_wb_stb  <= 1'b1;
                     o_wb_data <= freq + step;
                  end else begin
                     state    <= S_DWELL;
                     o_wb_cyc <= 1'b0;
                     o_wb_we  <= 1'b0;
                     dcnt     <= dwell;
                  end
`endif
               end else if (tcnt >= TO_LAST) begin
                  state    <= S_DONE;
                  o_wb_cyc <= 1'b0;
                  o_wb_we  <= 1'b0;
                  o_err    <= 1'b1;
                  o_done   <= 1'b1;
               end else begin
                  tcnt <= tcnt + TO_W'(1);
                  if (i_abort) abort_pend <= 1'b1;
               end
            end
`ifdef FM_SWEEP_READBACK_EN
            S_RREQ: begin
               if (!i_wb_stall) begin
                  state    <= S_RACK;
                  o_wb_stb <= 1'b0;
                  tcnt     <= TO_W'(1);
                  if (i_abort) abort_pend <= 1'b1;
               end else if (abort_any) begin
                  state    <= S_DONE;
                  o_wb_cyc <= 1'b0;
                  o_wb_stb <= 1'b0;
                  o_done   <= 1'b1;
               end
            end
            // o_wb_data still holds the value written for this point.
            S_RACK: begin
               if (i_wb_ack) begin
                  if (i_wb_data != o_wb_data || abort_any || remaining == 16'd0) begin
                     state    <= S_DONE;
                     o_wb_cyc <= 1'b0;
                     o_done   <= 1'b1;
                     if (i_wb_data != o_wb_data) o_err <= 1'b1;
                  end else if (dwell == '0) begin
                     state     <= S_REQ;
                     o_wb_stb  <= 1'b1;
                     o_wb_we   <= 1'b1;
                     o_wb_data <= freq;
                  end else begin
                     state    <= S_DWELL;
                     o_wb_cyc <= 1'b0;
                     dcnt     <= dwell;
                  end
               end else if (tcnt >= TO_LAST) begin
                  state    <= S_DONE;
                  o_wb_cyc <= 1'b0;
                  o_err    <= 1'b1;
                  o_done   <= 1'b1;
               end else begin
                  tcnt <= tcnt + TO_W'(1);
                  if (i_abort) abort_pend <= 1'b1;
               end
            end
`endif
            S_DWELL: begin
               if (abort_any) begin
                  state  <= S_DONE;
                  o_done <= 1'b1;
               end else if (dcnt == DWELL_W'(1)) begin
                  state     <= S_REQ;
                  o_wb_cyc  <= 1'b1;
                  o_wb_stb  <= 1'b1;
                  o_wb_we   <= 1'b1;
                  o_wb_data <= freq;
               end else begin
                  dcnt <= dcnt - DWELL_W'(1);
               end
            end
            S_DONE: begin
               state      <= S_IDLE;
               o_busy     <= 1'b0;
               abort_pend <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fm_sweep_wb_master.sv
// Bench for fm_sweep_wb_master: timeline model of the sweep plus a scripted Wishbone slave.
module tb_fm_sweep_wb_master;
   logic        clk = 1'b0;
   logic        i_reset, i_start, i_abort;
   logic [31:0] i_start_freq, i_step;
   logic [15:0] i_count;
   logic [23:0] i_dwell;
   logic        o_busy, o_done, o_err, o_wb_cyc, o_wb_stb, o_wb_we;
   logic [1:0]  o_wb_addr;
   logic [31:0] o_wb_data;
   logic        i_wb_ack, i_wb_stall;
   logic [31:0] i_wb_data;

   fm_sweep_wb_master #(.ADDR_W(2), .DWELL_W(24), .TIMEOUT(15)) dut (
      .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_abort(i_abort),
      .i_start_freq(i_start_freq), .i_step(i_step), .i_count(i_count), .i_dwell(i_dwell),
      .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
      .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
      .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
      .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_data(i_wb_data));

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0;
   int cur_k = 0;

   // Expected per-cycle outputs, index = cycles after the start cycle.
   logic        e_stb [64], e_cyc [64], e_we [64], e_done [64], e_busy [64], e_err [64];
   logic [31:0] e_data [64];
   int          e_len;
   logic        model_err = 1'b0;

   // Slave script and record of accepted writes.
   int          stall_left = 0;
   bit          sl_noack = 0, sl_bad = 0, ack_next = 0;
   logic [31:0] last_wr = '0;
   int          nwr = 0, done_k = -1;
   int          wr_k [16];
   logic [31:0] wr_d [16];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp, input int k);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s (cycle %0d): got %h, expected %h", nm, k, act, exp);
   endtask

   always @(posedge clk) begin
      #2;
      i_wb_ack   = ack_next && !sl_noack;
      ack_next   = 0;
      i_wb_stall = 1'b0;
      if (o_wb_cyc && o_wb_stb) begin
         if (stall_left > 0) begin
            i_wb_stall = 1'b1;
            stall_left--;
         end else begin
            ack_next = 1;
            if (o_wb_we) begin
               if (nwr < 16) begin
                  wr_k[nwr] = cur_k;
                  wr_d[nwr] = o_wb_data;
               end
               nwr++;
               last_wr = o_wb_data;
            end else begin
               i_wb_data = sl_bad ? 32'h0 : last_wr;
            end
         end
      end
   end

   // Timeline model: where each strobe, ack window, dwell and done must fall.
   task automatic build(input logic [31:0] sf, input logic [31:0] st, input int cnt, input int dw,
                        input int stall0, input bit noack, input bit bad, input int ab);
      int t, a, base, done_at;
      bit err_now;
      logic [31:0] f, wr;
      for (int k = 0; k < 64; k++) begin
         e_stb[k] = 0; e_cyc[k] = 0; e_we[k] = 0; e_done[k] = 0; e_busy[k] = 0;
         e_err[k] = model_err; e_data[k] = '0;
      end
      if (ab == 0) begin
         e_len = 6;
         return;
      end
      done_at = (cnt == 0) ? 1 : -1;
      err_now = 0; f = sf; t = 1; base = 0; wr = '0;
      for (int i = 0; i < cnt; i++) begin
         if (done_at < 0) begin
            a = t + ((i == 0) ? stall0 : 0);
            for (int c = t; c <= a; c++) begin
               if (done_at < 0) begin
                  e_cyc[c] = 1; e_stb[c] = 1; e_we[c] = 1; e_data[c] = f;
                  if (ab == c && c < a) done_at = c + 1;
               end
            end
            if (done_at < 0 && noack && i == 0) begin
               for (int c = a + 1; c < a + 15; c++) e_cyc[c] = 1;
               done_at = a + 15;
               err_now = 1;
            end
            if (done_at < 0) begin
               e_cyc[a+1] = 1;
               wr = f;
               f = f + st;
`ifdef FM_SWEEP_READBACK_EN
               if (ab == a || ab == a + 1) done_at = a + 2;
               else begin
                  e_cyc[a+2] = 1; e_cyc[a+3] = 1;
                  e_stb[a+2] = 1; e_we[a+2] = 0; e_data[a+2] = wr;
                  if (bad) begin
                     done_at = a + 4;
                     err_now = 1;
                  end else if (i == cnt - 1 || ab == a + 2 || ab == a + 3) done_at = a + 4;
               end
               base = a + 4;
`else
               if (i == cnt - 1 || ab == a || ab == a + 1) done_at = a + 2;
               base = a + 2;
`endif
               for (int c = base; c < base + dw; c++)
                  if (done_at < 0 && ab == c) done_at = c + 1;
               t = base + dw;
            end
         end
      end
      e_done[done_at] = 1;
      for (int k = 1; k < 64; k++) begin
         e_busy[k] = (k <= done_at);
         e_err[k]  = (k >= done_at) ? err_now : 1'b0;
      end
      model_err = err_now;
      e_len = done_at + 3;
   endtask

   task automatic run(input logic [31:0] sf, input logic [31:0] st, input int cnt, input int dw,
                      input int stall0, input bit noack, input bit bad, input int ab);
      build(sf, st, cnt, dw, stall0, noack, bad, ab);
      stall_left = stall0; sl_noack = noack; sl_bad = bad; ack_next = 0;
      nwr = 0; done_k = -1;
      i_start_freq = sf; i_step = st; i_count = 16'(cnt); i_dwell = 24'(dw);
      for (int k = 0; k < e_len; k++) begin
         @(posedge clk);
         #1;
         cur_k = k;
         chk("busy", 32'(o_busy), 32'(e_busy[k]), k);
         chk("done", 32'(o_done), 32'(e_done[k]), k);
         chk("err",  32'(o_err),  32'(e_err[k]),  k);
         chk("stb",  32'(o_wb_stb), 32'(e_stb[k]), k);
         chk("cyc",  32'(o_wb_cyc), 32'(e_cyc[k]), k);
         if (e_stb[k]) begin
            chk("we",   32'(o_wb_we), 32'(e_we[k]), k);
            chk("data", o_wb_data, e_data[k], k);
            chk("addr", 32'(o_wb_addr), 32'h0, k);
         end
         if (o_done && done_k < 0) done_k = k;
         #1;
         i_start = (k == 0);
         i_abort = (k == ab);
      end
      i_start = 0;
      i_abort = 0;
   endtask

   initial begin
      i_reset = 1; i_start = 0; i_abort = 0;
      i_start_freq = '0; i_step = '0; i_count = '0; i_dwell = '0;
      i_wb_ack = 0; i_wb_stall = 0; i_wb_data = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", 32'(o_busy), 32'h0, 0);
      chk("reset_done", 32'(o_done), 32'h0, 0);
      chk("reset_err",  32'(o_err),  32'h0, 0);
      chk("reset_bus",  {29'd0, o_wb_cyc, o_wb_stb, o_wb_we}, 32'h0, 0);
      chk("reset_data", o_wb_data, 32'h0, 0);
      #1 i_reset = 0;

      // Nominal sweep.
      run(32'h0044_4444, 32'h100, 3, 2, 0, 0, 0, -1);
      chk("t1_nwr", 32'(nwr), 32'd3, 0);
      chk("t1_d0", wr_d[0], 32'h0044_4444, 0);
      chk("t1_d1", wr_d[1], 32'h0044_4544, 0);
      chk("t1_d2", wr_d[2], 32'h0044_4644, 0);
`ifndef FM_SWEEP_READBACK_EN
      chk("t1_k0", 32'(wr_k[0]), 32'd1, 0);
      chk("t1_k1", 32'(wr_k[1]), 32'd5, 0);
      chk("t1_k2", 32'(wr_k[2]), 32'd9, 0);
      chk("t1_done", 32'(done_k), 32'd11, 0);
`endif
      chk("t1_err", 32'(o_err), 32'h0, 0);

      // Stall on the first strobe.
      run(32'h0044_4444, 32'h100, 3, 2, 3, 0, 0, -1);
      chk("t2_k0", 32'(wr_k[0]), 32'd4, 0);
      chk("t2_d0", wr_d[0], 32'h0044_4444, 0);

      // Wrap-around, back-to-back points.
      run(32'hFFFF_FFF0, 32'h20, 2, 0, 0, 0, 0, -1);
      chk("t3_d1", wr_d[1], 32'h0000_0010, 0);

      // Zero-length sweep.
      run(32'h1234, 32'h1, 0, 5, 0, 0, 0, -1);
      chk("t4_nwr", 32'(nwr), 32'd0, 0);
      chk("t4_done", 32'(done_k), 32'd1, 0);

      // Abort during dwell of point 2 of 5.
      run(32'h1000, 32'h10, 5, 3, 0, 0, 0, 9);
      chk("t5_nwr", 32'(nwr), 32'd2, 0);
`ifndef FM_SWEEP_READBACK_EN
      chk("t5_done", 32'(done_k), 32'd10, 0);
`endif

      // Slave never acks.
      run(32'h55, 32'h1, 2, 0, 0, 1, 0, -1);
      chk("t6_done", 32'(done_k), 32'd16, 0);
      chk("t6_err", 32'(o_err), 32'h1, 0);

      // Start and abort together: start ignored, error flag untouched.
      run(32'h77, 32'h1, 2, 0, 0, 0, 0, 0);
      chk("t7_nwr", 32'(nwr), 32'd0, 0);

      // Abort while strobe is stalled, then abort in the ack window.
      run(32'h88, 32'h1, 2, 1, 3, 0, 0, 2);
      chk("t8_nwr", 32'(nwr), 32'd0, 0);
      run(32'h99, 32'h1, 3, 1, 0, 0, 0, 2);
      chk("t9_nwr", 32'(nwr), 32'd1, 0);

`ifdef FM_SWEEP_READBACK_EN
      run(32'hAB, 32'h1, 3, 1, 0, 0, 1, -1);
      chk("rb_nwr", 32'(nwr), 32'd1, 0);
      chk("rb_err", 32'(o_err), 32'h1, 0);
`endif

      // Asynchronous reset while the strobe is up.
      i_start_freq = 32'h42; i_step = 32'h1; i_count = 16'd4; i_dwell = 24'd0;
      stall_left = 5; sl_noack = 0;
      @(posedge clk); #2 i_start = 1;
      @(posedge clk); #2 i_start = 0;
      chk("rst_pre_stb", 32'(o_wb_stb), 32'h1, 0);
      #1 i_reset = 1;
      #1;
      chk("rst_cyc", 32'(o_wb_cyc), 32'h0, 0);
      chk("rst_stb", 32'(o_wb_stb), 32'h0, 0);
      chk("rst_busy", 32'(o_busy), 32'h0, 0);
      @(posedge clk); #2 i_reset = 0;
      stall_left = 0;
      model_err = 1'b0;
      run(32'h10, 32'h10, 2, 1, 0, 0, 0, -1);
      chk("post_rst_d0", wr_d[0], 32'h10, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
